// File: rtl/rst_seq.sv
// rst_seq: reset sequencer placed directly after the reset synchronizer.
//
// Holds memory/mapper, PPU and CPU/APU in reset until the PLL lock has been
// stable for LOCK_HOLD cycles and the debounced front-panel button is
// released. It then releases the resets in order (mem, ppu, cpu), one stage
// every STAGE_GAP cycles. Lock loss or a button press aborts back to WAIT.
//
// Optional feature, macro RSTSEQ_SOFTRST_EN: adds i_soft_rst and a SOFT state.
// A soft reset pulse in RUN re-asserts the PPU and CPU resets while keeping
// memory/mapper out of reset, then re-enters the sequence at the PPU stage.
//
// Ports:
//   i_clk        system clock
//   i_rstn       asynchronous active-low reset (already synchronized release)
//   i_pll_locked PLL lock, asynchronous to i_clk
//   i_btn_n      reset button, active low, asynchronous and bouncing
//   i_soft_rst   (RSTSEQ_SOFTRST_EN only) one-cycle soft reset request
//   o_mem_rstn   memory/mapper reset, active low, released first
//   o_ppu_rstn   PPU reset, active low, released second
//   o_cpu_rstn   CPU/APU reset, active low, released last
//   o_ready      high when all resets are released
module rst_seq #(
    parameter int unsigned LOCK_HOLD    = 16,
    parameter int unsigned STAGE_GAP    = 8,
    parameter int unsigned DEBOUNCE_CYC = 1000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_pll_locked,
    input  logic i_btn_n,
`ifdef RSTSEQ_SOFTRST_EN
    input  logic i_soft_rst,
`endif
    output logic o_mem_rstn,
    output logic o_ppu_rstn,
    output logic o_cpu_rstn,
    output logic o_ready
);

    localparam logic [2:0] StWait = 3'd0;
    localparam logic [2:0] StHold = 3'd1;
    localparam logic [2:0] StMem  = 3'd2;
    localparam logic [2:0] StPpu  = 3'd3;
    localparam logic [2:0] StRun  = 3'd4;
`ifdef RSTSEQ_SOFTRST_EN
    localparam logic [2:0] StSoft = 3'd5;
`endif

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(LOCK_HOLD - 1);
    localparam logic [CNT_W-1:0] GapLast  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYC - 1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [1:0] lock_sync_q;
    logic [1:0] btn_sync_q;
    logic       lock_s;
    logic       btn_s;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            lock_sync_q <= 2'b00;
            btn_sync_q  <= 2'b11;
        end else begin
            lock_sync_q <= {lock_sync_q[0], i_pll_locked};
            btn_sync_q  <= {btn_sync_q[0], i_btn_n};
        end
    end

    assign lock_s = lock_sync_q[1];
    assign btn_s  = btn_sync_q[1];

    // ------------------------------------------------------------------
    // Button debounce: a new level is accepted only after it has been
    // seen for DEBOUNCE_CYC consecutive cycles.
    // ------------------------------------------------------------------
    logic             btn_db_q;
    logic             btn_db_d;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] dcnt_d;

    always_comb begin
        btn_db_d = btn_db_q;
        dcnt_d   = '0;
        if (btn_s != btn_db_q) begin
            if (dcnt_q == DbLast) begin
                btn_db_d = btn_s;
            end else begin
                dcnt_d = dcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            btn_db_q <= 1'b1;
            dcnt_q   <= '0;
        end else begin
            btn_db_q <= btn_db_d;
            dcnt_q   <= dcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    logic             abort;
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign abort = !lock_s || !btn_db_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = StWait;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StWait: begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
                StHold: begin
                    if (cnt_q == HoldLast) begin
                        state_d = StMem;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StMem: begin
                    if (cnt_q == GapLast) begin
                        state_d = StPpu;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StPpu: begin
                    if (cnt_q == GapLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StRun: begin
                    cnt_d = '0;
`ifdef RSTSEQ_SOFTRST_EN
                    if (i_soft_rst) begin
                        state_d = StSoft;
                    end
`endif
                end
`ifdef RSTSEQ_SOFTRST_EN
                // Memory stays released; rejoin the sequence at the PPU stage.
                StSoft: begin
                    if (cnt_q == GapLast) begin
                        state_d = StPpu;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StWait;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered, decoded from the next state so they switch on
    // the same edge as the state and cannot glitch.
    // ------------------------------------------------------------------
    logic mem_rel;
    logic ppu_rel;
    logic cpu_rel;

    always_comb begin
        mem_rel = 1'b0;
        ppu_rel = 1'b0;
        cpu_rel = 1'b0;
        case (state_d)
            StMem: begin
                mem_rel = 1'b1;
            end
            StPpu: begin
                mem_rel = 1'b1;
                ppu_rel = 1'b1;
            end
            StRun: begin
                mem_rel = 1'b1;
                ppu_rel = 1'b1;
                cpu_rel = 1'b1;
            end
`ifdef RSTSEQ_SOFTRST_EN
            StSoft: begin
                mem_rel = 1'b1;
            end
`endif
            default: begin
                mem_rel = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_mem_rstn <= 1'b0;
            o_ppu_rstn <= 1'b0;
            o_cpu_rstn <= 1'b0;
            o_ready    <= 1'b0;
        end else begin
            o_mem_rstn <= mem_rel;
            o_ppu_rstn <= ppu_rel;
            o_cpu_rstn <= cpu_rel;
            o_ready    <= cpu_rel;
        end
    end

endmodule
